pulse_sweep_ctrl: RTL and testbench

- Sequences the pulse generator through an automated delay sweep: n_points delay values, starting at base_del and incremented by del_step, with shots_per_pt pulse periods at each point.
- Sits between the UART parameter block and the pulse-generation block.
- Drives the delay word consumed by the pulse block and gates pulse generation via run_en.
- Advances only on period boundaries, so a delay never changes mid-sequence.

---
 rtl/pulse_sweep_ctrl_if.sv | 46 ++++
 rtl/pulse_sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pulse_sweep_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_sweep_ctrl_if.sv
// rtl/pulse_sweep_ctrl_if.sv - control/status bundle between sweep controller and its neighbours
//
// Purpose: carries sweep requests, sweep configuration, the pulse-block period
// strobe and all controller status outputs as one bundle.
// Modports:
//   slave  - the sweep controller (consumes requests/config, drives status)
//   master - the surrounding logic or testbench (drives requests/config)
// Signals:
//   start, abort, rxd, cycle_end      request / strobe inputs to the controller
//   base_del, del_step                first delay and per-point increment (DW)
//   n_points, shots_per_pt            sweep geometry (PW, SW)
//   del_out, run_en, busy             delay word and pulse gating
//   pt_idx, shot_cnt                  sweep position
//   pt_done, sweep_done, sat          completion strobes and clamp flag
interface pulse_sweep_ctrl_if #(
  parameter int DW = 16,
  parameter int PW = 8,
  parameter int SW = 16
);
  logic          start;
  logic          abort;
  logic          rxd;
  logic          cycle_end;
  logic [DW-1:0] base_del;
  logic [DW-1:0] del_step;
  logic [PW-1:0] n_points;
  logic [SW-1:0] shots_per_pt;
  logic [DW-1:0] del_out;
  logic          run_en;
  logic          busy;
  logic [PW-1:0] pt_idx;
  logic [SW-1:0] shot_cnt;
  logic          pt_done;
  logic          sweep_done;
  logic          sat;

  modport slave (
    input  start, abort, rxd, cycle_end, base_del, del_step, n_points, shots_per_pt,
    output del_out, run_en, busy, pt_idx, shot_cnt, pt_done, sweep_done, sat
  );

  modport master (
    output start, abort, rxd, cycle_end, base_del, del_step, n_points, shots_per_pt,
    input  del_out, run_en, busy, pt_idx, shot_cnt, pt_done, sweep_done, sat
  );
endinterface

// File: rtl/pulse_sweep_ctrl.sv
// rtl/pulse_sweep_ctrl.sv - automated delay sweep sequencer for the pulse generator
//
// Purpose: steps the pulse block's delay word through n_points values starting
// at base_del in increments of del_step, holding each value for shots_per_pt
// pulse periods. All changes happen on period boundaries (cycle_end).
// Ports:
//   clk     system clock, shared with the pulse block
//   resetn  asynchronous active-low reset
//   bus     pulse_sweep_ctrl_if.slave: requests, configuration, status outputs
module pulse_sweep_ctrl #(
  parameter int DW = 16,
  parameter int PW = 8,
  parameter int SW = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  pulse_sweep_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_nxt;

  // Shadow copies of the sweep geometry. The starting delay needs no shadow:
  // del_out itself is loaded with base_del when the sweep is accepted.
  logic [DW-1:0] step_sh;
  logic [PW-1:0] npts_sh;
  logic [SW-1:0] shots_sh;
  logic          load_shadow;

  logic [DW-1:0] del_q, del_nxt;
  logic [PW-1:0] pt_q, pt_nxt;
  logic [SW-1:0] shot_q, shot_nxt;
  logic          sat_q, sat_nxt;
  logic          pt_done_q, pt_done_nxt;
  logic          sweep_done_q;
  logic          run_en_q;
  logic          busy_q;

  logic          stop;
  logic          cfg_ok;
  logic          start_ok;
  logic          last_shot;
  logic          last_pt;
  logic [DW:0]   del_sum;

  // A new parameter strobe from the UART block invalidates the sweep just
  // like an explicit abort.
  assign stop      = bus.abort | bus.rxd;
  assign cfg_ok    = (bus.n_points != '0) && (bus.shots_per_pt != '0);
  assign start_ok  = bus.start && cfg_ok;
  assign last_shot = (shot_q == shots_sh - SW'(1));
  assign last_pt   = (pt_q == npts_sh - PW'(1));
  // One extra bit so the carry out of the delay increment is visible.
  assign del_sum   = {1'b0, del_q} + {1'b0, step_sh};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; abort/rxd outrank cycle_end, which outranks start
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_nxt = ARM;
      end
      ARM: begin
        if (stop)               state_nxt = IDLE;
        else if (bus.cycle_end) state_nxt = RUN;
      end
      RUN: begin
        if (stop)                                       state_nxt = IDLE;
        else if (bus.cycle_end && last_shot && last_pt) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered datapath/status outputs
  always_comb begin
    del_nxt     = del_q;
    pt_nxt      = pt_q;
    shot_nxt    = shot_q;
    sat_nxt     = sat_q;
    pt_done_nxt = 1'b0;
    load_shadow = 1'b0;
    case (state_q)
      IDLE: begin
        // Pass-through keeps non-sweep operation following the UART setting.
        del_nxt = bus.base_del;
        if (start_ok) begin
          load_shadow = 1'b1;
          pt_nxt      = '0;
          shot_nxt    = '0;
          sat_nxt     = 1'b0;
        end
      end
      RUN: begin
        if (!stop && bus.cycle_end) begin
          if (!last_shot) begin
            shot_nxt = shot_q + SW'(1);
          end else begin
            shot_nxt    = '0;
            pt_done_nxt = 1'b1;
            if (!last_pt) begin
              pt_nxt = pt_q + PW'(1);
              if (del_sum[DW]) begin
                del_nxt = '1;
                sat_nxt = 1'b1;
              end else begin
                del_nxt = del_sum[DW-1:0];
              end
            end
          end
        end
      end
      default: begin
        // ARM and DONE hold every datapath value; abort leaves pt_idx and
        // shot_cnt frozen for readout.
      end
    endcase
  end

  // Shadow registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_sh  <= '0;
      npts_sh  <= '0;
      shots_sh <= '0;
    end else if (load_shadow) begin
      step_sh  <= bus.del_step;
      npts_sh  <= bus.n_points;
      shots_sh <= bus.shots_per_pt;
    end
  end

  // Output registers; status flags derive from the state being entered so
  // they line up with the registered state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      del_q        <= '0;
      pt_q         <= '0;
      shot_q       <= '0;
      sat_q        <= 1'b0;
      pt_done_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      run_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      del_q        <= del_nxt;
      pt_q         <= pt_nxt;
      shot_q       <= shot_nxt;
      sat_q        <= sat_nxt;
      pt_done_q    <= pt_done_nxt;
      sweep_done_q <= (state_nxt == DONE);
      run_en_q     <= (state_nxt != DONE);
      busy_q       <= (state_nxt == ARM) || (state_nxt == RUN);
    end
  end

  assign bus.del_out    = del_q;
  assign bus.pt_idx     = pt_q;
  assign bus.shot_cnt   = shot_q;
  assign bus.sat        = sat_q;
  assign bus.pt_done    = pt_done_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.run_en     = run_en_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pulse_sweep_ctrl.sv
// tb/tb_pulse_sweep_ctrl.sv - self-checking bench for pulse_sweep_ctrl
module tb_pulse_sweep_ctrl;

  logic clk;
  logic resetn;

  pulse_sweep_ctrl_if #(.DW(16), .PW(8), .SW(16)) bus ();

  pulse_sweep_ctrl #(.DW(16), .PW(8), .SW(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] del;
    logic [7:0]  pt;
    logic [15:0] shot;
    logic        pt_done;
    logic        sweep_done;
    logic        busy;
    logic        run_en;
    logic        sat;
  } obs_t;

  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t mk(input logic [15:0] d, input logic [7:0] p, input logic [15:0] s,
                              input logic pd, input logic sd, input logic b, input logic r,
                              input logic st);
    obs_t o;
    o.del = d; o.pt = p; o.shot = s; o.pt_done = pd; o.sweep_done = sd;
    o.busy = b; o.run_en = r; o.sat = st;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.del_out, bus.pt_idx, bus.shot_cnt, bus.pt_done, bus.sweep_done,
              bus.busy, bus.run_en, bus.sat);
  endfunction

  task automatic check(input string tag);
    obs_t exp_o;
    obs_t got_o;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      exp_o = sb.pop_front();
      got_o = sample();
      checks++;
      assert (got_o === exp_o) else begin
        failures++;
        $error("FAIL %s observed del=%h pt=%0d shot=%0d pd=%b sd=%b busy=%b run=%b sat=%b expected del=%h pt=%0d shot=%0d pd=%b sd=%b busy=%b run=%b sat=%b",
               tag, got_o.del, got_o.pt, got_o.shot, got_o.pt_done, got_o.sweep_done,
               got_o.busy, got_o.run_en, got_o.sat,
               exp_o.del, exp_o.pt, exp_o.shot, exp_o.pt_done, exp_o.sweep_done,
               exp_o.busy, exp_o.run_en, exp_o.sat);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive cycle_end/start for one clock, record the expected outcome, compare.
  task automatic cyc(input logic ce, input logic st, input obs_t e, input string tag);
    bus.cycle_end = ce;
    bus.start     = st;
    sb.push_back(e);
    tick();
    bus.cycle_end = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.rxd       = 1'b0;
    check(tag);
  endtask

  task automatic cfg(input logic [15:0] b, input logic [15:0] s, input logic [7:0] n,
                     input logic [15:0] k);
    bus.base_del = b; bus.del_step = s; bus.n_points = n; bus.shots_per_pt = k;
  endtask

  // Sweep to pt_idx=1, shot_cnt=1, then stop it with abort or rxd on a cycle_end.
  task automatic run_abort(input logic use_rxd, input string tag);
    cfg(16'd100, 16'd10, 8'd3, 16'd2);
    cyc(1'b0, 1'b1, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), {tag, "_arm"});
    cyc(1'b1, 1'b0, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), {tag, "_s1"});
    cyc(1'b1, 1'b0, mk(16'd100, 8'd0, 16'd1, 0, 0, 1, 1, 0), {tag, "_s2"});
    cyc(1'b1, 1'b0, mk(16'd110, 8'd1, 16'd0, 1, 0, 1, 1, 0), {tag, "_s3"});
    cyc(1'b1, 1'b0, mk(16'd110, 8'd1, 16'd1, 0, 0, 1, 1, 0), {tag, "_s4"});
    if (use_rxd) bus.rxd = 1'b1;
    else         bus.abort = 1'b1;
    cyc(1'b1, 1'b0, mk(16'd110, 8'd1, 16'd1, 0, 0, 0, 1, 0), {tag, "_stop"});
    cyc(1'b0, 1'b0, mk(16'd100, 8'd1, 16'd1, 0, 0, 0, 1, 0), {tag, "_idle"});
  endtask

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.rxd = 1'b0; bus.cycle_end = 1'b0;
    cfg(16'd100, 16'd10, 8'd3, 16'd2);
    #2;
    sb.push_back(mk(16'd0, 8'd0, 16'd0, 0, 0, 0, 0, 0));
    check("reset");
    tick();
    resetn = 1'b1;
    cyc(1'b0, 1'b0, mk(16'd100, 8'd0, 16'd0, 0, 0, 0, 1, 0), "idle_follow");

    // Basic sweep: 3 points x 2 shots
    cyc(1'b0, 1'b1, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), "b_arm");
    cyc(1'b1, 1'b0, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), "b_s1");
    cyc(1'b1, 1'b0, mk(16'd100, 8'd0, 16'd1, 0, 0, 1, 1, 0), "b_s2");
    cyc(1'b1, 1'b0, mk(16'd110, 8'd1, 16'd0, 1, 0, 1, 1, 0), "b_s3");
    cyc(1'b0, 1'b0, mk(16'd110, 8'd1, 16'd0, 0, 0, 1, 1, 0), "b_gap");
    cyc(1'b1, 1'b0, mk(16'd110, 8'd1, 16'd1, 0, 0, 1, 1, 0), "b_s4");
    cyc(1'b1, 1'b0, mk(16'd120, 8'd2, 16'd0, 1, 0, 1, 1, 0), "b_s5");
    cyc(1'b1, 1'b0, mk(16'd120, 8'd2, 16'd1, 0, 0, 1, 1, 0), "b_s6");
    cyc(1'b1, 1'b0, mk(16'd120, 8'd2, 16'd0, 1, 1, 0, 0, 0), "b_s7_done");
    bus.base_del = 16'd300;
    cyc(1'b0, 1'b0, mk(16'd120, 8'd2, 16'd0, 0, 0, 0, 1, 0), "b_post1");
    cyc(1'b0, 1'b0, mk(16'd300, 8'd2, 16'd0, 0, 0, 0, 1, 0), "b_post2");

    // Zero configuration is ignored
    cfg(16'd300, 16'd10, 8'd0, 16'd2);
    cyc(1'b0, 1'b1, mk(16'd300, 8'd2, 16'd0, 0, 0, 0, 1, 0), "zero_npts");
    cfg(16'd300, 16'd10, 8'd3, 16'd0);
    cyc(1'b0, 1'b1, mk(16'd300, 8'd2, 16'd0, 0, 0, 0, 1, 0), "zero_shots");
    cyc(1'b0, 1'b0, mk(16'd300, 8'd2, 16'd0, 0, 0, 0, 1, 0), "zero_stay");

    // Saturation
    cfg(16'hFFF0, 16'h0020, 8'd2, 16'd1);
    cyc(1'b0, 1'b1, mk(16'hFFF0, 8'd0, 16'd0, 0, 0, 1, 1, 0), "sat_arm");
    cyc(1'b1, 1'b0, mk(16'hFFF0, 8'd0, 16'd0, 0, 0, 1, 1, 0), "sat_s1");
    cyc(1'b1, 1'b0, mk(16'hFFFF, 8'd1, 16'd0, 1, 0, 1, 1, 1), "sat_clamp");
    cyc(1'b1, 1'b0, mk(16'hFFFF, 8'd1, 16'd0, 1, 1, 0, 0, 1), "sat_done");
    cyc(1'b0, 1'b0, mk(16'hFFFF, 8'd1, 16'd0, 0, 0, 0, 1, 1), "sat_post1");
    cyc(1'b0, 1'b0, mk(16'hFFF0, 8'd1, 16'd0, 0, 0, 0, 1, 1), "sat_sticky");

    // Abort and rxd mid-RUN (first start also clears sat)
    run_abort(1'b0, "abort");
    run_abort(1'b1, "rxd");

    // Asynchronous reset during RUN
    cfg(16'd100, 16'd10, 8'd3, 16'd2);
    cyc(1'b0, 1'b1, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), "rst_arm");
    cyc(1'b1, 1'b0, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), "rst_s1");
    cyc(1'b1, 1'b0, mk(16'd100, 8'd0, 16'd1, 0, 0, 1, 1, 0), "rst_s2");
    #1;
    resetn = 1'b0;
    #1;
    sb.push_back(mk(16'd0, 8'd0, 16'd0, 0, 0, 0, 0, 0));
    check("rst_async");
    tick();
    resetn = 1'b1;
    cyc(1'b0, 1'b0, mk(16'd100, 8'd0, 16'd0, 0, 0, 0, 1, 0), "rst_idle");
    cyc(1'b0, 1'b1, mk(16'd100, 8'd0, 16'd0, 0, 0, 1, 1, 0), "rst_restart");
    bus.abort = 1'b1;
    cyc(1'b0, 1'b0, mk(16'd100, 8'd0, 16'd0, 0, 0, 0, 1, 0), "rst_abort_arm");

    // Isolation: inputs change and start pulses during the sweep
    cfg(16'd200, 16'd5, 8'd2, 16'd1);
    cyc(1'b0, 1'b1, mk(16'd200, 8'd0, 16'd0, 0, 0, 1, 1, 0), "iso_arm");
    cfg(16'd999, 16'd77, 8'd9, 16'd4);
    cyc(1'b1, 1'b1, mk(16'd200, 8'd0, 16'd0, 0, 0, 1, 1, 0), "iso_s1");
    cyc(1'b1, 1'b0, mk(16'd205, 8'd1, 16'd0, 1, 0, 1, 1, 0), "iso_s2");
    cyc(1'b1, 1'b1, mk(16'd205, 8'd1, 16'd0, 1, 1, 0, 0, 0), "iso_done");
    cyc(1'b0, 1'b0, mk(16'd205, 8'd1, 16'd0, 0, 0, 0, 1, 0), "iso_post1");
    cyc(1'b0, 1'b0, mk(16'd999, 8'd1, 16'd0, 0, 0, 0, 1, 0), "iso_post2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
